// File: rtl/layer3_pool_ctrl.sv
// layer3_pool_ctrl
// Frame-level sequencer between the conv3 output stream and the layer-3
// max-pool channel array. For each feature map it accepts one map of pixels
// over a valid/ready handshake and forwards every pixel to the array with a
// one-cycle start pulse. It then counts the array's output-valid pulses
// against the expected pooled total, and finally reports completion or
// raises a sticky error.
//
// Ports
//   clk_in       single clock, rising edge
//   rst          asynchronous active-high reset
//   frame_start  one-cycle pulse that begins a frame (honoured only in IDLE)
//   in_valid     upstream pixel valid
//   in_ready     upstream pixel accepted when in_valid & in_ready
//   in_data      all-channel pixel word
//   out_ready    downstream may accept pooled results; low stalls intake
//   pool_data    registered pixel word to the pool array
//   pool_start   one-cycle pulse aligned with pool_data
//   pool_ready   pool array (channel 0) output-valid pulse
//   busy         high while a frame is being fed or drained
//   frame_done   one-cycle pulse at frame end
//   out_cnt      pooled outputs counted in the current frame
//   pix_row      row of the next pixel to accept
//   pix_col      column of the next pixel to accept
//   err          sticky error flag
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for frame_start, intake closed
// S_RUN   | accepting pixels, in_ready follows out_ready
// S_DRAIN | all pixels sent, waiting for remaining pool_ready pulses
// S_DONE  | one-cycle frame_done, then back to idle
module layer3_pool_ctrl #(
    parameter int bits          = 16,
    parameter int channel_num   = 16,
    parameter int map_w         = 8,
    parameter int map_h         = 8,
    parameter int pool_k        = 2,
    parameter int drain_timeout = 64,
    localparam int W            = channel_num * bits,
    localparam int OUT_TOTAL    = (map_w / pool_k) * (map_h / pool_k),
    localparam int CNT_W        = $clog2(OUT_TOTAL + 1),
    localparam int ROW_W        = (map_h > 1) ? $clog2(map_h) : 1,
    localparam int COL_W        = (map_w > 1) ? $clog2(map_w) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             out_ready,
    output logic [W-1:0]     pool_data,
    output logic             pool_start,
    input  logic             pool_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] out_cnt,
    output logic [ROW_W-1:0] pix_row,
    output logic [COL_W-1:0] pix_col,
    output logic             err
);

    localparam int DR_W = (drain_timeout > 1) ? $clog2(drain_timeout) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DR_W-1:0] drain_cnt;
    logic            accept;
    logic            last_pix;
    logic            cnt_full;
    logic            drain_tc;
    logic            start_ok;
    logic            timeout;
    logic            spurious;

    assign in_ready   = (state == S_RUN) && out_ready;
    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign frame_done = (state == S_DONE);

    assign accept   = in_valid && in_ready;
    assign last_pix = (pix_row == ROW_W'(map_h - 1)) && (pix_col == COL_W'(map_w - 1));
    assign cnt_full = (out_cnt == CNT_W'(OUT_TOTAL));
    assign drain_tc = (drain_cnt == '0);
    assign start_ok = (state == S_IDLE) && frame_start;
    // Completion has priority over an expiring drain timer in the same cycle.
    assign timeout  = (state == S_DRAIN) && !cnt_full && drain_tc;
    // A pulse outside the frame, or beyond the expected total, is a violation.
    assign spurious = pool_ready && (!busy || cnt_full);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_start) state_nxt = S_RUN;
            S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
            S_DRAIN: if (cnt_full || drain_tc) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pool_data  <= '0;
            pool_start <= 1'b0;
            out_cnt    <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            err        <= 1'b0;
            drain_cnt  <= DR_W'(drain_timeout - 1);
        end else begin
            pool_start <= accept;
            if (accept) begin
                pool_data <= in_data;
            end

            if (start_ok) begin
                pix_row <= '0;
                pix_col <= '0;
                out_cnt <= '0;
            end else begin
                if (accept) begin
                    if (pix_col == COL_W'(map_w - 1)) begin
                        pix_col <= '0;
                        pix_row <= (pix_row == ROW_W'(map_h - 1)) ? '0 : pix_row + ROW_W'(1);
                    end else begin
                        pix_col <= pix_col + COL_W'(1);
                    end
                end
                if (pool_ready && busy && !cnt_full) begin
                    out_cnt <= out_cnt + CNT_W'(1);
                end
            end

            // Drain timer: reloaded whenever outside DRAIN, so it starts
            // fresh on entry and expires after drain_timeout DRAIN cycles.
            if (state != S_DRAIN) begin
                drain_cnt <= DR_W'(drain_timeout - 1);
            end else if (!drain_tc) begin
                drain_cnt <= drain_cnt - DR_W'(1);
            end

            // Setting wins over clearing when both happen in one cycle.
            if (start_ok) begin
                err <= 1'b0;
            end
            if (spurious || timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer3_pool_ctrl.sv
module tb_layer3_pool_ctrl;
    localparam int BITS = 16;
    localparam int CH   = 16;
    localparam int MW   = 8;
    localparam int MH   = 8;
    localparam int PK   = 2;
    localparam int DT   = 64;
    localparam int W    = BITS * CH;
    localparam int PIX  = MW * MH;
    localparam int OUTS = (MW / PK) * (MH / PK);

    logic         clk_in = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic [W-1:0] pool_data;
    logic         pool_start;
    logic         pool_ready;
    logic         busy;
    logic         frame_done;
    logic [4:0]   out_cnt;
    logic [2:0]   pix_row;
    logic [2:0]   pix_col;
    logic         err;

    layer3_pool_ctrl #(
        .bits(BITS), .channel_num(CH), .map_w(MW), .map_h(MH),
        .pool_k(PK), .drain_timeout(DT)
    ) dut (
        .clk_in(clk_in), .rst(rst), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_ready(out_ready), .pool_data(pool_data), .pool_start(pool_start),
        .pool_ready(pool_ready), .busy(busy), .frame_done(frame_done),
        .out_cnt(out_cnt), .pix_row(pix_row), .pix_col(pix_col), .err(err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: pixels accepted and pooled outputs counted this frame
    int           m_pix;
    int           m_outs;
    logic [W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_in(input bit v, input bit o, input bit pr, input bit fs);
        in_valid    = v;
        out_ready   = o;
        pool_ready  = pr;
        frame_start = fs;
        for (int i = 0; i < W / 32; i++) in_data[32*i +: 32] = $urandom;
    endtask

    task automatic apply_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        set_in(0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0);
        m_pix  = 0;
        m_outs = 0;
        exp_q.delete();
    endtask

    // One intake cycle: drive, sample pre-edge values, update model, step.
    task automatic pix_cycle(input bit v, input bit o, input bit pr,
                             output bit acc, output logic ir,
                             output logic [2:0] row, output logic [2:0] col,
                             output logic ps, output logic [W-1:0] pd);
        set_in(v, o, pr, 0);
        #1;
        ir  = in_ready;
        row = pix_row;
        col = pix_col;
        acc = v && o && (m_pix < PIX);
        if (acc) begin
            exp_q.push_back(in_data);
            m_pix++;
        end
        if (pr && m_outs < OUTS) m_outs++;
        tick();
        ps = pool_start;
        pd = pool_data;
    endtask

    task automatic wait_done(input int max_cyc, output int first, output int cnt,
                             output logic busy_at);
        first   = -1;
        cnt     = 0;
        busy_at = 1'bx;
        set_in(0, 0, 0, 0);
        for (int j = 0; j < max_cyc; j++) begin
            if (frame_done === 1'b1) begin
                if (first < 0) begin
                    first   = j;
                    busy_at = busy;
                end
                cnt++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 1, 1);
        #3;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (pool_data !== '0) $display("FAIL reset_pool_data: got %h want 0", pool_data); else n_pass++;
        n_checks++; if (pool_start !== 1'b0) $display("FAIL reset_pool_start: got %b want 0", pool_start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (out_cnt !== 5'd0) $display("FAIL reset_out_cnt: got %0d want 0", out_cnt); else n_pass++;
        n_checks++; if (pix_row !== 3'd0) $display("FAIL reset_pix_row: got %0d want 0", pix_row); else n_pass++;
        n_checks++; if (pix_col !== 3'd0) $display("FAIL reset_pix_col: got %0d want 0", pix_col); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        apply_reset();
    endtask

    task automatic test_nominal();
        bit acc; logic ir, ps; logic [2:0] r, c; logic [W-1:0] pd, e;
        int first, cnt; logic b;
        start_frame();
        out_ready = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL nom_busy_start: got %b want 1", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL nom_ready_start: got %b want 1", in_ready); else n_pass++;
        for (int i = 0; i < PIX; i++) begin
            pix_cycle(1, 1, (i % 5 == 4), acc, ir, r, c, ps, pd);
            e = exp_q.pop_front();
            n_checks++; if (ir !== 1'b1) $display("FAIL nom_in_ready px%0d: got %b want 1", i, ir); else n_pass++;
            n_checks++; if ({r, c} !== {3'(i / MW), 3'(i % MW)}) $display("FAIL nom_rowcol px%0d: got %0d,%0d want %0d,%0d", i, r, c, i / MW, i % MW); else n_pass++;
            n_checks++; if (ps !== 1'b1) $display("FAIL nom_pool_start px%0d: got %b want 1", i, ps); else n_pass++;
            n_checks++; if (pd !== e) $display("FAIL nom_pool_data px%0d: got %h want %h", i, pd, e); else n_pass++;
            n_checks++; if (out_cnt !== 5'(m_outs)) $display("FAIL nom_out_cnt px%0d: got %0d want %0d", i, out_cnt, m_outs); else n_pass++;
        end
        set_in(1, 1, 0, 0);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL nom_drain_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL nom_drain_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if ({pix_row, pix_col} !== 6'd0) $display("FAIL nom_wrap: got %0d,%0d want 0,0", pix_row, pix_col); else n_pass++;
        for (int k = 0; k < OUTS - m_outs + k; k++) begin
            if (m_outs >= OUTS) break;
            if (k > 0) begin set_in(0, 1, 0, 0); tick(); end
            set_in(0, 1, 1, 0);
            tick();
            m_outs++;
            if (k == 0) begin
                n_checks++; if (pool_start !== 1'b0) $display("FAIL nom_drain_start: got %b want 0", pool_start); else n_pass++;
            end
            n_checks++; if (out_cnt !== 5'(m_outs)) $display("FAIL nom_drain_cnt: got %0d want %0d", out_cnt, m_outs); else n_pass++;
        end
        wait_done(10, first, cnt, b);
        n_checks++; if (first !== 1) $display("FAIL nom_done_time: got %0d want 1", first); else n_pass++;
        n_checks++; if (cnt !== 1) $display("FAIL nom_done_count: got %0d want 1", cnt); else n_pass++;
        n_checks++; if (b !== 1'b0) $display("FAIL nom_done_busy: got %b want 0", b); else n_pass++;
        n_checks++; if (out_cnt !== 5'(OUTS)) $display("FAIL nom_final_cnt: got %0d want %0d", out_cnt, OUTS); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL nom_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit acc; logic ir, ps; logic [2:0] r, c; logic [W-1:0] pd, e;
        int first, cnt, k, starts, pre; logic b; bit o, v;
        start_frame();
        k = 0;
        starts = 0;
        while (m_pix < PIX && k < 2000) begin
            o = ((k / 3) % 2) == 0;
            v = 1'($urandom_range(0, 1));
            pix_cycle(v, o, 0, acc, ir, r, c, ps, pd);
            pre = m_pix - int'(acc);
            if (ps === 1'b1) starts++;
            n_checks++; if (ir !== o) $display("FAIL bp_in_ready cyc%0d: got %b want %b", k, ir, o); else n_pass++;
            n_checks++; if ({r, c} !== {3'(pre / MW), 3'(pre % MW)}) $display("FAIL bp_rowcol cyc%0d: got %0d,%0d want %0d,%0d", k, r, c, pre / MW, pre % MW); else n_pass++;
            n_checks++; if (ps !== acc) $display("FAIL bp_pool_start cyc%0d: got %b want %b", k, ps, acc); else n_pass++;
            if (acc) begin
                e = exp_q.pop_front();
                n_checks++; if (pd !== e) $display("FAIL bp_pool_data px%0d: got %h want %h", pre, pd, e); else n_pass++;
            end
            k++;
        end
        if (k >= 2000) begin
            n_checks++;
            $display("FAIL bp_budget: accepted %0d want %0d", m_pix, PIX);
        end
        n_checks++; if (starts !== PIX) $display("FAIL bp_starts: got %0d want %0d", starts, PIX); else n_pass++;
        set_in(1, 1, 0, 0);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_drain_ready: got %b want 0", in_ready); else n_pass++;
        for (int j = 0; j < OUTS; j++) begin
            set_in(0, 1, 1, 0);
            tick();
        end
        wait_done(10, first, cnt, b);
        n_checks++; if (first !== 1 || cnt !== 1) $display("FAIL bp_done: got first=%0d count=%0d want first=1 count=1", first, cnt); else n_pass++;
        n_checks++; if (out_cnt !== 5'(OUTS)) $display("FAIL bp_final_cnt: got %0d want %0d", out_cnt, OUTS); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL bp_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_timeout();
        bit acc; logic ir, ps; logic [2:0] r, c; logic [W-1:0] pd;
        start_frame();
        for (int i = 0; i < PIX; i++) pix_cycle(1, 1, 0, acc, ir, r, c, ps, pd);
        for (int j = 0; j < DT; j++) begin
            set_in(0, 0, (j < OUTS - 1), 0);
            n_checks++; if ({busy, err, frame_done} !== 3'b100) $display("FAIL to_drain dc%0d: got busy/err/done=%b want 100", j, {busy, err, frame_done}); else n_pass++;
            tick();
        end
        n_checks++; if (frame_done !== 1'b1) $display("FAIL to_frame_done: got %b want 1", frame_done); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL to_err: got %b want 1", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (out_cnt !== 5'(OUTS - 1)) $display("FAIL to_out_cnt: got %0d want %0d", out_cnt, OUTS - 1); else n_pass++;
        set_in(0, 0, 0, 0);
        tick();
        n_checks++; if ({frame_done, err} !== 2'b01) $display("FAIL to_sticky: got done/err=%b want 01", {frame_done, err}); else n_pass++;
        start_frame();
        n_checks++; if (err !== 1'b0) $display("FAIL to_err_clear: got %b want 0", err); else n_pass++;
        n_checks++; if (out_cnt !== 5'd0) $display("FAIL to_cnt_clear: got %0d want 0", out_cnt); else n_pass++;
        apply_reset();
    endtask

    task automatic test_spurious();
        bit acc; logic ir, ps; logic [2:0] r, c; logic [W-1:0] pd;
        set_in(0, 0, 1, 0);
        tick();
        n_checks++; if ({err, out_cnt} !== {1'b1, 5'd0}) $display("FAIL sp_idle: got err=%b cnt=%0d want err=1 cnt=0", err, out_cnt); else n_pass++;
        set_in(0, 0, 0, 0);
        tick();
        n_checks++; if (err !== 1'b1) $display("FAIL sp_idle_sticky: got %b want 1", err); else n_pass++;
        start_frame();
        n_checks++; if (err !== 1'b0) $display("FAIL sp_clear: got %b want 0", err); else n_pass++;
        for (int i = 0; i < PIX; i++) pix_cycle(1, 1, (i < OUTS - 1), acc, ir, r, c, ps, pd);
        n_checks++; if ({err, out_cnt} !== {1'b0, 5'(m_outs)}) $display("FAIL sp_run: got err=%b cnt=%0d want err=0 cnt=%0d", err, out_cnt, m_outs); else n_pass++;
        set_in(0, 0, 1, 0);
        tick();
        n_checks++; if ({busy, err, out_cnt} !== {1'b1, 1'b0, 5'(OUTS)}) $display("FAIL sp_16th: got busy=%b err=%b cnt=%0d want 1 0 %0d", busy, err, out_cnt, OUTS); else n_pass++;
        set_in(0, 0, 1, 0);
        tick();
        n_checks++; if ({frame_done, err} !== 2'b11) $display("FAIL sp_17th: got done/err=%b want 11", {frame_done, err}); else n_pass++;
        n_checks++; if (out_cnt !== 5'(OUTS)) $display("FAIL sp_sat: got %0d want %0d", out_cnt, OUTS); else n_pass++;
        set_in(0, 0, 0, 0);
        tick();
        n_checks++; if ({err, out_cnt} !== {1'b1, 5'(OUTS)}) $display("FAIL sp_hold: got err=%b cnt=%0d want 1 %0d", err, out_cnt, OUTS); else n_pass++;
    endtask

    task automatic test_ignored_start_reset();
        bit acc; logic ir, ps; logic [2:0] r, c; logic [W-1:0] pd, e;
        int first, cnt, k, starts; logic b;
        start_frame();
        for (int i = 0; i < 20; i++) pix_cycle(1, 1, (i == 3 || i == 9 || i == 15), acc, ir, r, c, ps, pd);
        set_in(0, 1, 0, 1);
        tick();
        n_checks++; if ({pix_row, pix_col} !== {3'(20 / MW), 3'(20 % MW)}) $display("FAIL ign_rowcol: got %0d,%0d want %0d,%0d", pix_row, pix_col, 20 / MW, 20 % MW); else n_pass++;
        n_checks++; if (out_cnt !== 5'(m_outs)) $display("FAIL ign_cnt: got %0d want %0d", out_cnt, m_outs); else n_pass++;
        n_checks++; if ({busy, err} !== 2'b10) $display("FAIL ign_state: got busy/err=%b want 10", {busy, err}); else n_pass++;
        for (int i = 20; i < 30; i++) pix_cycle(1, 1, 0, acc, ir, r, c, ps, pd);
        set_in(1, 1, 1, 0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, pool_start, busy, frame_done, err, out_cnt, pix_row, pix_col, pool_data} !== '0)
            $display("FAIL mid_reset: got rdy=%b st=%b busy=%b done=%b err=%b cnt=%0d row=%0d col=%0d data_nonzero=%b want all 0",
                     in_ready, pool_start, busy, frame_done, err, out_cnt, pix_row, pix_col, |pool_data);
        else n_pass++;
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        n_checks++; if (frame_done !== 1'b0) $display("FAIL mid_reset_done: got %b want 0", frame_done); else n_pass++;
        start_frame();
        k = 0;
        starts = 0;
        while (m_pix < PIX && k < 1000) begin
            pix_cycle(1'($urandom_range(0, 1)), 1, 0, acc, ir, r, c, ps, pd);
            if (ps === 1'b1) starts++;
            if (acc) begin
                e = exp_q.pop_front();
                n_checks++; if (pd !== e) $display("FAIL clean_pool_data px%0d: got %h want %h", m_pix - 1, pd, e); else n_pass++;
            end
            k++;
        end
        n_checks++; if (starts !== PIX) $display("FAIL clean_starts: got %0d want %0d", starts, PIX); else n_pass++;
        for (int j = 0; j < OUTS; j++) begin
            set_in(0, 0, 1, 0);
            tick();
        end
        wait_done(10, first, cnt, b);
        n_checks++; if (first !== 1 || cnt !== 1) $display("FAIL clean_done: got first=%0d count=%0d want 1 1", first, cnt); else n_pass++;
        n_checks++; if ({err, out_cnt} !== {1'b0, 5'(OUTS)}) $display("FAIL clean_final: got err=%b cnt=%0d want 0 %0d", err, out_cnt, OUTS); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_spurious();
        test_ignored_start_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer3_pool_ctrl.md
# layer3_pool_ctrl

Frame-level sequencer for the layer-3 max-pool channel array. It sits between the conv3 output stream and the pool array. Once per feature map it:
- accepts exactly one map of pixels through a valid/ready handshake;
- registers each pixel and issues one start pulse per pixel to the array;
- counts the array's ready pulses against the expected pooled-output total;
- reports completion, or raises a sticky error on protocol violation or timeout.

## Interface
Parameters:
- bits, 16, quantization width per channel
- channel_num, 16, channels processed in parallel; bus width W = channel_num*bits
- map_w, 8, input feature-map width in pixels
- map_h, 8, input feature-map height in pixels
- pool_k, 2, pooling window edge; map_w and map_h must be multiples of pool_k
- drain_timeout, 64, maximum cycles in DRAIN before error
- Derived constants: PIX_TOTAL = map_w*map_h; OUT_TOTAL = (map_w/pool_k)*(map_h/pool_k)

Ports:
- clk_in  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  upstream pixel accepted when in_valid & in_ready
- in_data  in  W  all-channel pixel word
- out_ready  in  1  downstream may accept pooled results; 0 stalls intake
- pool_data  out  W  registered pixel word to the pool array
- pool_start  out  1  one-cycle pulse, aligned with pool_data
- pool_ready  in  1  pool array (channel 0) output-valid pulse
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse at frame end
- out_cnt  out  clog2(OUT_TOTAL+1)  pooled outputs counted in the current frame
- pix_row  out  clog2(map_h)  row of the next pixel to accept
- pix_col  out  clog2(map_w)  column of the next pixel to accept
- err  out  1  sticky error flag

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE
  - in_ready = 0.
  - On frame_start: clear pix_row, pix_col and out_cnt; clear err; go to RUN.
- RUN
  - in_ready = out_ready (combinational).
  - On each accept:
    - pool_data <= in_data and pool_start <= 1 for the next cycle; otherwise pool_start <= 0.
    - pix_col increments; at map_w-1 it wraps to 0 and pix_row increments.
  - Accepting pixel (map_h-1, map_w-1) goes to DRAIN and leaves row/col wrapped to 0.
- DRAIN
  - in_ready = 0. The drain cycle counter is cleared on entry.
  - When out_cnt == OUT_TOTAL: go to DONE.
  - If the counter reaches drain_timeout first: set err, go to DONE.
- DONE
  - frame_done = 1 for exactly this cycle, then go to IDLE.
  - out_cnt holds its value until the next frame_start.
- pool_ready handling
  - In RUN or DRAIN: out_cnt increments, saturating at OUT_TOTAL.
  - A pulse arriving when out_cnt is already OUT_TOTAL sets err.
  - A pulse in IDLE or DONE sets err and is not counted.
- frame_start in RUN, DRAIN or DONE is ignored and has no side effects.
- err clears only on reset or on an accepted frame_start.

## Timing
- Reset (asynchronous, immediate) leaves state IDLE and every output at 0: in_ready, pool_data, pool_start, busy, frame_done, out_cnt, pix_row, pix_col, err.
- Input to array latency: 1 cycle, accepted pixel to pool_start/pool_data.
- Throughput: one pixel per cycle while in_valid and out_ready are both held high.
- Stalls: in_valid low or out_ready low inserts a bubble, and pool_start stays 0.
- State timing:
  - frame_start at cycle t gives busy = 1 and in_ready live from cycle t+1.
  - The last accept at cycle t gives DRAIN from t+1.
  - DONE is entered the cycle after out_cnt reaches OUT_TOTAL. frame_done is high in that cycle and busy drops in the same cycle.
- Simultaneous events:
  - pool_ready in the same cycle as the last accept is counted.
  - If the count completes in that same cycle, the block still passes through DRAIN for one cycle.
- Reset mid-frame returns to IDLE immediately. Partial counts are discarded and no frame_done is issued.

## Test plan
- Nominal frame (defaults): frame_start, then 64 back-to-back pixels, then 16 pool_ready pulses spread over RUN and DRAIN -> exactly 64 pool_start pulses, each 1 cycle after its accept; out_cnt = 16; one frame_done; err = 0.
- Backpressure: out_ready toggles every 3 cycles and in_valid is random -> in_ready tracks out_ready only in RUN; exactly 64 accepts; pool_data equals the accepted in_data in order; pix_row/pix_col wrap correctly at (0,7)->(1,0).
- Timeout: only 15 pool_ready pulses -> err = 1 at drain cycle 64; frame_done pulses; out_cnt = 15; next frame_start clears err.
- Spurious ready: pool_ready in IDLE, and a 17th pulse in DRAIN -> err = 1; out_cnt never exceeds 16.
- Ignored start, then reset: frame_start mid-RUN -> counters unchanged. rst asserted at pixel 30 -> all outputs 0 immediately; a new frame then runs cleanly with 64 accepts.
